pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 110 +++++++++++
 tb/tb_pipe_stage_reg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline register between fetch and decode, with branch flush and optional NOP injection.
// Buffering depth is selected by PIPE_STAGE_SKID_EN: defined gives a 2-entry skid buffer, undefined gives 1.
module pipe_stage_reg #(
  parameter int unsigned        PC_W       = 32,
  parameter int unsigned        INST_W     = 32,
  parameter logic [INST_W-1:0]  NOP_INST   = INST_W'(32'h0340_0000),
  parameter bit                 INJECT_NOP = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  input  logic              flush_i,
  output logic [1:0]        level_o
);

  logic [1:0]        r_level;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [PC_W-1:0]   r_pc [2];
  logic [INST_W-1:0] r_inst [2];
  logic [PC_W-1:0]   r_last_pc;

  logic [1:0]        w_level_d;
  logic [PC_W-1:0]   w_pc_d [2];
  logic [INST_W-1:0] w_inst_d [2];
  logic [PC_W-1:0]   w_last_pc_d;
  logic              w_acc;
  logic              w_cons;
  logic [1:0]        w_pop_level;

  assign w_acc       = in_valid_i & in_ready_o;
  assign w_cons      = r_out_valid & out_ready_i;
  assign w_pop_level = r_level - {1'b0, w_cons};

  // Entry 0 is the head; a pop shifts entry 1 down, then a push lands in the first free slot.
  always_comb begin
    w_level_d   = r_level;
    w_pc_d[0]   = r_pc[0];
    w_pc_d[1]   = r_pc[1];
    w_inst_d[0] = r_inst[0];
    w_inst_d[1] = r_inst[1];
    w_last_pc_d = r_last_pc;
    if (flush_i) begin
      if (INJECT_NOP) begin
        w_level_d   = 2'd1;
        w_pc_d[0]   = r_last_pc;
        w_inst_d[0] = NOP_INST;
      end else begin
        w_level_d   = 2'd0;
      end
    end else begin
      if (w_cons) begin
        w_pc_d[0]   = r_pc[1];
        w_inst_d[0] = r_inst[1];
      end
      if (w_acc) begin
        w_pc_d[w_pop_level[0]]   = in_pc_i;
        w_inst_d[w_pop_level[0]] = in_inst_i;
        w_last_pc_d              = in_pc_i;
      end
      w_level_d = w_pop_level + {1'b0, w_acc};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_level     <= 2'd0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_pc[0]     <= '0;
      r_pc[1]     <= '0;
      r_inst[0]   <= '0;
      r_inst[1]   <= '0;
      r_last_pc   <= '0;
    end else begin
      r_level     <= w_level_d;
      r_out_valid <= (w_level_d != 2'd0);
      r_pc[0]     <= w_pc_d[0];
      r_pc[1]     <= w_pc_d[1];
      r_inst[0]   <= w_inst_d[0];
      r_inst[1]   <= w_inst_d[1];
      r_last_pc   <= w_last_pc_d;
`ifdef PIPE_STAGE_SKID_EN
      r_in_ready  <= (w_level_d < 2'd2);
`else
      // Only acts as an out-of-reset enable in the single-entry build.
      r_in_ready  <= 1'b1;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready_o = r_in_ready;
`else
  assign in_ready_o = r_in_ready & (~r_out_valid | out_ready_i);
`endif

  assign out_valid_o = r_out_valid;
  assign out_pc_o    = r_pc[0];
  assign out_inst_o  = r_inst[0];
  assign level_o     = r_level;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (NOP injection on / off) against a queue-based reference model.
// Directed scenarios followed by randomized traffic with flushes and occasional resets.
module tb_pipe_stage_reg;

  localparam logic [31:0] Nop = 32'h0340_0000;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif
  localparam int Cap = Skid ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic [1:0]       o_valid;
  logic [1:0]       o_rdy;
  logic [1:0][31:0] o_pc;
  logic [1:0][31:0] o_inst;
  logic [1:0][1:0]  o_level;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.INJECT_NOP(1'b1)) u_dut_nop (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(o_rdy[0]),
    .in_pc_i(in_pc), .in_inst_i(in_inst), .out_valid_o(o_valid[0]), .out_ready_i(out_ready),
    .out_pc_o(o_pc[0]), .out_inst_o(o_inst[0]), .flush_i(flush), .level_o(o_level[0])
  );

  pipe_stage_reg #(.INJECT_NOP(1'b0)) u_dut_empty (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_ready_o(o_rdy[1]),
    .in_pc_i(in_pc), .in_inst_i(in_inst), .out_valid_o(o_valid[1]), .out_ready_i(out_ready),
    .out_pc_o(o_pc[1]), .out_inst_o(o_inst[1]), .flush_i(flush), .level_o(o_level[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {pc, inst} beats per instance (0: NOP inject, 1: empty).
  logic [63:0] m_ent [2][4];
  int          m_cnt [2];
  logic [31:0] m_last [2];
  bit          m_rdy [2];
  bit          m_en [2];

  function automatic bit exp_rdy(input int m);
    if (Skid) return m_rdy[m];
    return m_en[m] && (m_cnt[m] == 0 || out_ready);
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_last[m] = '0; m_rdy[m] = 1'b0; m_en[m] = 1'b0;
    end
  end

  always @(posedge clk) begin : model
    bit acc, cons;
    for (int m = 0; m < 2; m++) begin
      if (!rst_i) begin
        m_cnt[m] = 0; m_last[m] = '0; m_rdy[m] = 1'b0; m_en[m] = 1'b0;
      end else begin
        acc  = in_valid && exp_rdy(m);
        cons = (m_cnt[m] > 0) && out_ready;
        if (flush) begin
          m_cnt[m] = 0;
          if (m == 0) begin
            m_ent[m][0] = {m_last[m], Nop};
            m_cnt[m] = 1;
          end
        end else begin
          if (cons) begin
            for (int i = 0; i < 3; i++) m_ent[m][i] = m_ent[m][i+1];
            m_cnt[m]--;
          end
          if (acc) begin
            m_ent[m][m_cnt[m]] = {in_pc, in_inst};
            m_cnt[m]++;
            m_last[m] = in_pc;
          end
        end
        m_en[m]  = 1'b1;
        m_rdy[m] = (m_cnt[m] < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check_eq($sformatf("d%0d.valid", m), 64'(o_valid[m]), 64'(m_cnt[m] > 0));
        check_eq($sformatf("d%0d.level", m), 64'(o_level[m]), 64'(m_cnt[m]));
        check_eq($sformatf("d%0d.in_ready", m), 64'(o_rdy[m]), 64'(exp_rdy(m)));
        check_eq($sformatf("d%0d.level_cap", m), 64'(int'(o_level[m]) <= Cap), 64'd1);
        if (m_cnt[m] > 0) begin
          check_eq($sformatf("d%0d.payload", m), {o_pc[m], o_inst[m]}, m_ent[m][0]);
        end
        if (!Skid && o_valid[m]) begin
          check_eq($sformatf("d%0d.rdy_follows_out", m), 64'(o_rdy[m]), 64'(out_ready));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = pc ^ 32'hA5A5_0000;
  endtask

  initial begin
    // Reset held for 3 edges while upstream is offering a beat.
    send(32'h0000_0010);
    repeat (3) step();
    for (int m = 0; m < 2; m++) begin
      check_eq("rst.valid", 64'(o_valid[m]), 64'd0);
      check_eq("rst.level", 64'(o_level[m]), 64'd0);
      check_eq("rst.in_ready", 64'(o_rdy[m]), 64'd0);
      check_eq("rst.pc", 64'(o_pc[m]), 64'd0);
    end
    in_valid = 1'b0;
    rst_i = 1'b1;
    step();
    check_eq("rel.in_ready", 64'(o_rdy[0]), 64'd1);
    check_eq("rel.in_ready_b", 64'(o_rdy[1]), 64'd1);
    chk_en = 1'b1;

    // Stream at full throughput.
    out_ready = 1'b1;
    send(32'h100); step();
    check_eq("stream.pc0", 64'(o_pc[0]), 64'h100);
    check_eq("stream.v0", 64'(o_valid[0]), 64'd1);
    send(32'h104); step();
    check_eq("stream.pc1", 64'(o_pc[0]), 64'h104);
    check_eq("stream.lvl1", 64'(o_level[0]), 64'd1);
    send(32'h108); step();
    check_eq("stream.pc2", 64'(o_pc[0]), 64'h108);
    check_eq("stream.inst2", 64'(o_inst[0]), 64'(32'h108 ^ 32'hA5A5_0000));
    in_valid = 1'b0; step();
    check_eq("stream.drain", 64'(o_valid[0]), 64'd0);

    if (Skid) begin
      out_ready = 1'b0;
      send(32'h200); step();
      send(32'h204); step();
      check_eq("stall.level", 64'(o_level[0]), 64'd2);
      check_eq("stall.in_ready", 64'(o_rdy[0]), 64'd0);
      check_eq("stall.pc", 64'(o_pc[0]), 64'h200);
      in_valid = 1'b0; step();
      check_eq("stall.hold", 64'(o_pc[0]), 64'h200);
      out_ready = 1'b1; step();
      check_eq("stall.next", 64'(o_pc[0]), 64'h204);
      check_eq("stall.lvl1", 64'(o_level[0]), 64'd1);
      step();
      check_eq("stall.empty", 64'(o_level[0]), 64'd0);
    end

    // Downstream ready toggling with continuous input.
    for (int k = 0; k < 6; k++) begin
      out_ready = (k % 3) != 1;
      send(32'h400 + 32'(4 * k));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Flush with a simultaneous input beat.
    out_ready = 1'b0;
    send(32'h300); step();
    check_eq("flush.pre", 64'(o_pc[0]), 64'h300);
    flush = 1'b1; send(32'h304); step();
    check_eq("flush.pc", 64'(o_pc[0]), 64'h300);
    check_eq("flush.inst", 64'(o_inst[0]), 64'(Nop));
    check_eq("flush.level", 64'(o_level[0]), 64'd1);
    check_eq("flush.valid", 64'(o_valid[0]), 64'd1);
    check_eq("flush0.valid", 64'(o_valid[1]), 64'd0);
    check_eq("flush0.level", 64'(o_level[1]), 64'd0);
    send(32'h308); step();
    check_eq("flush2.level", 64'(o_level[0]), 64'd1);
    check_eq("flush2.pc", 64'(o_pc[0]), 64'h300);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    check_eq("flush.drain", 64'(o_level[0]), 64'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      rst_i     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_inst   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    rst_i = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
